// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsuSize_e   - request size encoding (2'b11 is reserved and behaves as a word)
//   lsuState_e  - bus sequencing states
//   WORD_BYTES  - bytes per bus word
//   sizeBytes() - byte count for a size code
//   spans()     - true when an access crosses into the next bus word
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsuSize_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    RESP
  } lsuState_e;

  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    case (lsuSize_e'(size))
      LSU_BYTE: return 3'd1;
      LSU_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic spans(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + sizeBytes(size)) > 3'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/cpu_data_interface.sv
// CpuDataInterface: word-addressed data bus between the load/store unit
// (initiator) and the memory controller (target).
//   AddressBus   - word index (byte address >> 2)
//   DataWriteBus - write data, valid while WriteAssert is high
//   WriteAssert  - 1 = write cycle, 0 = read cycle
//   DataReadBus  - read data, valid while ReadOK is high
//   ReadOK       - target completes the read this cycle
//   WriteOK      - target completes the write this cycle
interface CpuDataInterface #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-3:0] AddressBus;
  logic [31:0]       DataWriteBus;
  logic              WriteAssert;
  logic [31:0]       DataReadBus;
  logic              ReadOK;
  logic              WriteOK;

  modport initiator (
    output AddressBus, DataWriteBus, WriteAssert,
    input  DataReadBus, ReadOK, WriteOK
  );

  modport target (
    input  AddressBus, DataWriteBus, WriteAssert,
    output DataReadBus, ReadOK, WriteOK
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational byte-lane logic over a {hi,lo} word pair.
//   loWord/hiWord - the two bus words touched by the access (hi=0 if no span)
//   offset        - byte offset of the access inside loWord
//   size          - lsuSize_e code
//   signedLoad    - sign-extend the extracted value
//   storeData     - right-justified store data
//   loadData      - extracted and extended load result
//   mergeLo/Hi    - read words with the store bytes merged in (little-endian)
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] loWord,
  input  logic [31:0] hiWord,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergeLo,
  output logic [31:0] mergeHi
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [63:0] storeWide;
  logic [63:0] merged;
  logic [7:0]  byteMask;

  always_comb begin
    shamt     = {offset, 3'b000};
    shifted   = 32'({hiWord, loWord} >> shamt);
    storeWide = {32'b0, storeData} << shamt;
    loadData  = shifted;
    byteMask  = 8'h0F << offset;
    merged    = '0;

    case (lsuSize_e'(size))
      LSU_BYTE: begin
        loadData = {{24{signedLoad & shifted[7]}}, shifted[7:0]};
        byteMask = 8'h01 << offset;
      end
      LSU_HALF: begin
        loadData = {{16{signedLoad & shifted[15]}}, shifted[15:0]};
        byteMask = 8'h03 << offset;
      end
      default: begin
        loadData = shifted;
        byteMask = 8'h0F << offset;
      end
    endcase

    for (int b = 0; b < 8; b++) begin
      merged[8*b +: 8] = byteMask[b] ? storeWide[8*b +: 8]
                                     : (b < 4 ? loWord[8*(b%4) +: 8] : hiWord[8*(b%4) +: 8]);
    end
  end

  assign mergeLo = merged[31:0];
  assign mergeHi = merged[63:32];

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word core requests at any alignment into
// aligned 32-bit CpuDataInterface cycles. Spanning loads use two reads;
// sub-word and spanning stores use read-modify-write.
//   CoreClock, Reset      - clock, asynchronous active-high reset
//   ReqValid/ReqReady     - request handshake (ready only in IDLE)
//   ReqWrite, ReqSize,
//   ReqSigned, ReqAddress,
//   ReqWriteData          - request fields
//   RespValid             - one-cycle completion pulse
//   RespReadData          - extended load result, held until next load response
//   cpuInterface          - bus initiator modport (all outputs registered)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CoreClock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [31:0]       ReqWriteData,
  output logic              RespValid,
  output logic [31:0]       RespReadData,
  CpuDataInterface.initiator cpuInterface
);

  localparam logic [ADDR_W-3:0] ONE_WORD = 1;

  lsuState_e state, stateNext;

  logic [ADDR_W-3:0] addrWord;
  logic [1:0]        offReg;
  logic [1:0]        sizeReg;
  logic              signedReg;
  logic              writeReg;
  logic [31:0]       wdataReg;
  logic [31:0]       loReg;
  logic [31:0]       hiReg;
  logic              spanReg;

  logic              accept;
  logic              alignedWordStore;
  logic [ADDR_W-3:0] loWordNext;
  logic [ADDR_W-3:0] addrNext;
  logic [31:0]       dataNext;
  logic [31:0]       laneLo;
  logic [31:0]       laneHi;
  logic [31:0]       loadData;
  logic [31:0]       mergeLo;
  logic [31:0]       mergeHi;

  assign ReqReady         = (state == IDLE);
  assign accept           = ReqReady && ReqValid;
  assign alignedWordStore = ReqWrite && (ReqAddress[1:0] == 2'b00) && (sizeBytes(ReqSize) == 3'd4);
  assign spanReg          = spans(offReg, sizeReg);
  assign loWordNext       = (state == IDLE) ? ReqAddress[ADDR_W-1:2] : addrWord;

  // The word being captured this cycle is fed straight into the lane so the
  // merged write data is ready on the same edge that leaves the read state.
  assign laneLo = (state == RD_LO) ? cpuInterface.DataReadBus : loReg;
  assign laneHi = (state == RD_HI) ? cpuInterface.DataReadBus : hiReg;

  lsu_byte_lane uLane (
    .loWord     (laneLo),
    .hiWord     (laneHi),
    .offset     (offReg),
    .size       (sizeReg),
    .signedLoad (signedReg),
    .storeData  (wdataReg),
    .loadData   (loadData),
    .mergeLo    (mergeLo),
    .mergeHi    (mergeHi)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (ReqValid) stateNext = alignedWordStore ? WR_LO : RD_LO;
      RD_LO:   if (cpuInterface.ReadOK)
                 stateNext = spanReg ? RD_HI : (writeReg ? WR_LO : RESP);
      RD_HI:   if (cpuInterface.ReadOK) stateNext = writeReg ? WR_LO : RESP;
      WR_LO:   if (cpuInterface.WriteOK) stateNext = spanReg ? WR_HI : RESP;
      WR_HI:   if (cpuInterface.WriteOK) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bus address/data only change on a state change, so they stay stable
  // through any number of stalled ReadOK/WriteOK cycles.
  always_comb begin
    addrNext = cpuInterface.AddressBus;
    dataNext = cpuInterface.DataWriteBus;
    if (stateNext != state) begin
      case (stateNext)
        RD_LO: addrNext = loWordNext;
        RD_HI: addrNext = addrWord + ONE_WORD;
        WR_LO: begin
          addrNext = loWordNext;
          dataNext = (state == IDLE) ? ReqWriteData : mergeLo;
        end
        WR_HI: begin
          addrNext = addrWord + ONE_WORD;
          dataNext = mergeHi;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CoreClock or posedge Reset) begin
    if (Reset) begin
      state                     <= IDLE;
      cpuInterface.AddressBus   <= '0;
      cpuInterface.DataWriteBus <= '0;
      cpuInterface.WriteAssert  <= 1'b0;
      RespValid                 <= 1'b0;
      RespReadData              <= '0;
    end else begin
      state                     <= stateNext;
      cpuInterface.AddressBus   <= addrNext;
      cpuInterface.DataWriteBus <= dataNext;
      cpuInterface.WriteAssert  <= (stateNext == WR_LO) || (stateNext == WR_HI);
      // The pulse lands on the edge leaving RESP, together with the result.
      RespValid                 <= (state == RESP);
      if ((state == RESP) && !writeReg) RespReadData <= loadData;
    end
  end

  always_ff @(posedge CoreClock) begin
    if (accept) begin
      addrWord  <= ReqAddress[ADDR_W-1:2];
      offReg    <= ReqAddress[1:0];
      sizeReg   <= ReqSize;
      signedReg <= ReqSigned;
      writeReg  <= ReqWrite;
      wdataReg  <= ReqWriteData;
      hiReg     <= '0;
    end
    if ((state == RD_LO) && cpuInterface.ReadOK) loReg <= cpuInterface.DataReadBus;
    if ((state == RD_HI) && cpuInterface.ReadOK) hiReg <= cpuInterface.DataReadBus;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        CoreClock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddress;
  logic [31:0] ReqWriteData;
  logic        RespValid;
  logic [31:0] RespReadData;

  always #5 CoreClock = ~CoreClock;

  CpuDataInterface #(.ADDR_W(32)) cpuBus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .CoreClock    (CoreClock),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddress   (ReqAddress),
    .ReqWriteData (ReqWriteData),
    .RespValid    (RespValid),
    .RespReadData (RespReadData),
    .cpuInterface (cpuBus)
  );

  logic [31:0] mem    [0:1023];
  logic [31:0] refMem [0:1023];

  assign cpuBus.DataReadBus = mem[cpuBus.AddressBus[9:0]];

  typedef struct {
    logic        isLoad;
    logic [31:0] data;
    int          acceptCyc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [29:0] idx;
    logic [31:0] data;
  } wr_t;

  resp_t respQ[$];
  wr_t   writeQ[$];

  int errCount   = 0;
  int checkCount = 0;
  int cyc        = 0;
  int respCount  = 0;

  always @(posedge CoreClock) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] refByte(input logic [31:0] a);
    return refMem[a[11:2]][8*a[1:0] +: 8];
  endfunction

  task automatic setWord(input int idx, input logic [31:0] v);
    mem[idx]    = v;
    refMem[idx] = v;
  endtask

  // Bus target + scoreboard: compares responses and writes as they appear.
  initial begin
    resp_t e;
    wr_t   w;
    forever begin
      @(negedge CoreClock);
      if (!Reset && RespValid) begin
        if (respQ.size() == 0) checkEq("spurious_resp", 32'd1, 32'd0);
        else begin
          e = respQ.pop_front();
          checkEq("latency", cyc - e.acceptCyc, e.lat);
          if (e.isLoad) checkEq("resp_data", RespReadData, e.data);
        end
        respCount++;
      end
      if (!Reset && cpuBus.WriteAssert && cpuBus.WriteOK) begin
        if (writeQ.size() == 0) checkEq("spurious_write", 32'd1, 32'd0);
        else begin
          w = writeQ.pop_front();
          checkEq("wr_addr", {2'b00, cpuBus.AddressBus}, {2'b00, w.idx});
          checkEq("wr_data", cpuBus.DataWriteBus, w.data);
        end
        mem[cpuBus.AddressBus[9:0]] = cpuBus.DataWriteBus;
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 of the RespValid cycle so the
  // next call exercises back-to-back acceptance.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    int          nb;
    int          off;
    logic        span;
    logic        awStore;
    logic [31:0] exp;
    logic [31:0] a;
    logic [29:0] loIdx;
    int          lat;
    int          start;
    resp_t       e;
    wr_t         w;

    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off     = int'(addr[1:0]);
    span    = (off + nb) > 4;
    awStore = wr && (off == 0) && (nb == 4);
    loIdx   = addr[31:2];
    exp     = '0;
    start   = respCount;

    if (!wr) begin
      for (int i = 0; i < 4; i++) begin
        a = addr + 32'(i);
        if (i < nb) exp[8*i +: 8] = refByte(a);
        else        exp[8*i +: 8] = (sgn && exp[8*nb-1]) ? 8'hFF : 8'h00;
      end
      lat = (span ? 3 : 2) + stall;
    end else begin
      for (int i = 0; i < nb; i++) begin
        a = addr + 32'(i);
        refMem[a[11:2]][8*a[1:0] +: 8] = wdata[8*i +: 8];
      end
      w.idx  = loIdx;
      w.data = refMem[loIdx[9:0]];
      writeQ.push_back(w);
      if (span) begin
        w.idx  = loIdx + 30'd1;
        w.data = refMem[w.idx[9:0]];
        writeQ.push_back(w);
      end
      lat = (awStore ? 2 : (span ? 5 : 3)) + stall;
    end

    ReqWrite     = wr;
    ReqSize      = size;
    ReqSigned    = sgn;
    ReqAddress   = addr;
    ReqWriteData = wdata;
    ReqValid     = 1'b1;
    checkEq("req_ready", {31'b0, ReqReady}, 32'd1);
    @(posedge CoreClock);
    #1;
    ReqValid    = 1'b0;
    e.isLoad    = !wr;
    e.data      = exp;
    e.acceptCyc = cyc;
    e.lat       = lat;
    respQ.push_back(e);
    checkEq("bus_addr", {2'b00, cpuBus.AddressBus}, {2'b00, loIdx});
    checkEq("wr_assert", {31'b0, cpuBus.WriteAssert}, {31'b0, awStore});

    if (stall > 0) begin
      cpuBus.ReadOK = 1'b0;
      repeat (stall) begin
        @(posedge CoreClock);
        #1;
        checkEq("stall_addr", {2'b00, cpuBus.AddressBus}, {2'b00, loIdx});
      end
      cpuBus.ReadOK = 1'b1;
    end

    for (int k = 0; k < 40 && respCount == start; k++) begin
      @(negedge CoreClock);
      #1;
    end
    if (respCount == start) checkEq("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rAddr;
    logic [1:0]  rSize;
    logic        rWr;
    int          rStall;

    Reset         = 1'b1;
    ReqValid      = 1'b0;
    ReqWrite      = 1'b0;
    ReqSize       = 2'b00;
    ReqSigned     = 1'b0;
    ReqAddress    = '0;
    ReqWriteData  = '0;
    cpuBus.ReadOK  = 1'b1;
    cpuBus.WriteOK = 1'b1;
    for (int i = 0; i < 1024; i++) setWord(i, (32'(i) * 32'h01010101) ^ 32'hA5C3_0F96);

    repeat (2) @(posedge CoreClock);
    #1;
    checkEq("rst_ready",  {31'b0, ReqReady}, 32'd1);
    checkEq("rst_resp",   {31'b0, RespValid}, 32'd0);
    checkEq("rst_rdata",  RespReadData, 32'd0);
    checkEq("rst_addr",   {2'b00, cpuBus.AddressBus}, 32'd0);
    checkEq("rst_wdata",  cpuBus.DataWriteBus, 32'd0);
    checkEq("rst_wassert", {31'b0, cpuBus.WriteAssert}, 32'd0);
    @(negedge CoreClock);
    #1;
    Reset = 1'b0;
    @(negedge CoreClock);
    #1;

    // Aligned word load
    setWord(32'h40, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0);
    checkEq("tp_word_load", RespReadData, 32'hDEADBEEF);

    // Signed and unsigned byte load of the top byte
    setWord(32'h40, 32'h80112233);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0);
    checkEq("tp_sbyte", RespReadData, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0);
    checkEq("tp_ubyte", RespReadData, 32'h00000080);

    // Spanning word load
    setWord(32'h7F, 32'hAABBCCDD);
    setWord(32'h80, 32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h1FE, 32'h0, 0);
    checkEq("tp_span_load", RespReadData, 32'h3344AABB);

    // Spanning half store
    setWord(32'h3F, 32'h44332211);
    setWord(32'h40, 32'h88776655);
    issue(1'b1, 2'b01, 1'b0, 32'h0FF, 32'h0000BEEF, 0);
    checkEq("tp_store_lo", mem[32'h3F], 32'hEF332211);
    checkEq("tp_store_hi", mem[32'h40], 32'h887766BE);

    // Word load with ReadOK held low 3 cycles
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3);
    checkEq("tp_stall_load", RespReadData, 32'h887766BE);

    // Aligned word store, sub-word store, reserved size, signed half
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h12345678, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h105, 32'hFFFFFFAB, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 0);
    checkEq("rsvd_size_load", RespReadData, 32'h1234AB78);
    issue(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 0);
    checkEq("shalf_load", RespReadData, 32'hFFFFAB78);

    // Address wrap at the top of the space
    setWord(32'h3FF, 32'h55667788);
    setWord(32'h000, 32'h99AABBCC);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 0);
    checkEq("wrap_load", RespReadData, 32'hBBCC5566);
    issue(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000F00D, 0);
    checkEq("wrap_store_lo", mem[32'h3FF], 32'h0D667788);
    checkEq("wrap_store_hi", mem[32'h000], 32'h99AABBF0);

    // Random mix
    for (int n = 0; n < 24; n++) begin
      rAddr  = 32'h200 + 32'($urandom_range(0, 255));
      rSize  = 2'($urandom_range(0, 3));
      rWr    = 1'($urandom_range(0, 1));
      rStall = (rWr && rSize[1] && rAddr[1:0] == 2'b00) ? 0 : $urandom_range(0, 2);
      issue(rWr, rSize, 1'($urandom_range(0, 1)), rAddr, $urandom, rStall);
    end

    // Reset while the high word of a spanning store is on the bus
    setWord(32'hBF, 32'h01020304);
    setWord(32'hC0, 32'h05060708);
    refMem[32'hBF][31:24] = 8'hFE;
    writeQ.push_back('{idx: 30'hBF, data: 32'hFE020304});
    ReqWrite     = 1'b1;
    ReqSize      = 2'b01;
    ReqSigned    = 1'b0;
    ReqAddress   = 32'h2FF;
    ReqWriteData = 32'h0000CAFE;
    ReqValid     = 1'b1;
    @(posedge CoreClock);
    #1;
    ReqValid = 1'b0;
    repeat (3) @(posedge CoreClock);
    #1;
    cpuBus.WriteOK = 1'b0;
    checkEq("wr_hi_wassert", {31'b0, cpuBus.WriteAssert}, 32'd1);
    checkEq("wr_hi_addr", {2'b00, cpuBus.AddressBus}, 32'hC0);
    @(negedge CoreClock);
    #2;
    Reset = 1'b1;
    #1;
    checkEq("async_rst_wassert", {31'b0, cpuBus.WriteAssert}, 32'd0);
    checkEq("async_rst_ready", {31'b0, ReqReady}, 32'd1);
    checkEq("async_rst_resp", {31'b0, RespValid}, 32'd0);
    repeat (2) @(posedge CoreClock);
    #1;
    Reset          = 1'b0;
    cpuBus.WriteOK = 1'b1;
    repeat (5) @(posedge CoreClock);
    #1;
    checkEq("post_rst_ready", {31'b0, ReqReady}, 32'd1);
    checkEq("post_rst_lo_word", mem[32'hBF], 32'hFE020304);
    checkEq("post_rst_hi_word", mem[32'hC0], 32'h05060708);
    @(negedge CoreClock);
    #1;

    // Unit still works after the abort
    issue(1'b0, 2'b01, 1'b0, 32'h2FF, 32'h0, 0);
    checkEq("post_rst_load", RespReadData, 32'h000008FE);

    checkEq("resp_queue_empty", respQ.size(), 32'd0);
    checkEq("write_queue_empty", writeQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CpuDataInterface bus: accepts byte, halfword and word load/store requests from the core pipeline and turns each one into word-aligned bus transactions. Aligned words map to one bus cycle. Unaligned and sub-word accesses are split and merged in hardware, using two reads for a word-spanning load and read-modify-write for stores. The unit sits between the core's memory stage and the memory controller, which only ever sees aligned 32-bit accesses.

## Interface
Parameters:
- ADDR_W, 32, width of request and bus addresses

Ports:
- CoreClock  in  1  single clock; all state on rising edge
- Reset  in  1  asynchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept; high only in IDLE
- ReqWrite  in  1  1 = store, 0 = load
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ReqSigned  in  1  sign-extend load result
- ReqAddress  in  ADDR_W  byte address, any alignment
- ReqWriteData  in  32  store data, right-justified
- RespValid  out  1  one-cycle completion pulse (loads and stores)
- RespReadData  out  32  extended load result; valid with RespValid, held until next RespValid
- cpuInterface  interface  CpuDataInterface  drives AddressBus, DataWriteBus, WriteAssert; samples DataReadBus, ReadOK, WriteOK

## Operation
- Accept on ReqValid && ReqReady in IDLE. Latch address, size, signed flag, write data and direction.
- off = addr[1:0]; nbytes = 1/2/4. Span = off + nbytes > 4 (half at off 3; word at off 1..3).
- LoAddr = {addr[31:2],2'b00}. HiAddr = LoAddr + 4, wrapping 0xFFFFFFFC -> 0x00000000.
- Byte order is little-endian.
- States and transitions:
  - IDLE -> RD_LO on accept, except aligned word store -> WR_LO.
  - RD_LO -> RD_HI if span, else WR_LO (store) or RESP (load).
  - RD_HI -> WR_LO (store) or RESP (load).
  - WR_LO -> WR_HI if span, else RESP.
  - WR_HI -> RESP.
  - RESP -> IDLE.
- Bus rules:
  - In RD_* the unit drives the matching word address with WriteAssert=0. It captures DataReadBus and advances in the cycle ReadOK=1, and holds otherwise.
  - In WR_* the unit drives address, merged data and WriteAssert=1. It advances in the cycle WriteOK=1, and holds otherwise.
  - In IDLE/RESP, WriteAssert=0 and the address holds its last value.
- Load extract: take the 64-bit {hi,lo} value (hi=0 if no span), shift right by off*8, keep nbytes, then zero- or sign-extend per ReqSigned.
- Store merge: shift the 64-bit {hi,lo} read data and ReqWriteData<<(off*8) under byte mask ((1<<nbytes)-1)<<off. Bytes outside the mask keep their read value.
- Bus outputs come straight from registers; no combinational path from Req* to cpuInterface.

## Timing
- Reset values: ReqReady=1, RespValid=0, RespReadData=0, AddressBus=0, DataWriteBus=0, WriteAssert=0, state IDLE.
- Latency from accept edge to RespValid with OK always high:
  - aligned word load: 2 cycles
  - spanning load: 3 cycles
  - aligned word store: 2 cycles
  - sub-word non-spanning store: 3 cycles
  - spanning store: 5 cycles
- Each deasserted ReadOK/WriteOK cycle adds exactly one cycle.
- Back-to-back: the next request is accepted the cycle after RESP.
- Reset mid-operation returns to IDLE and clears WriteAssert immediately (async) with no response. A reset during WR_HI leaves the low word written; this is accepted.
- Lo/hi words may be the same physical word only on wrap; there is no special case, and both accesses are issued.

## Structure
- Package lsu_pkg: ReqSize enum (LSU_BYTE/HALF/WORD), state enum, constant WORD_BYTES=4.
- Sub-module lsu_byte_lane: a combinational extract/merge over {hi,lo}, off and size, shared by the load and store paths.

## Test plan
- Aligned word load at 0x100 with DataReadBus=0xDEADBEEF, OK high -> bus address 0x40 (word index), RespValid 2 cycles after accept, RespReadData 0xDEADBEEF.
- Signed byte load at 0x103 with word 0x80112233 -> 0xFFFFFF80; the unsigned case gives 0x00000080.
- Word load at 0x1FE with lo=0xAABBCCDD, hi=0x11223344 -> reads at 0x1FC then 0x200, result 0x3344AABB.
- Half store 0xBEEF at 0x0FF with lo=0x44332211, hi=0x88776655 -> writes 0xEF332211 to 0x0FC and 0x887766BE to 0x100; RespValid 5 cycles after accept.
- Hold ReadOK low 3 cycles during RD_LO of a word load -> address stable, RespValid 3 cycles later than nominal.
- Assert Reset during WR_HI -> WriteAssert falls the same cycle, no RespValid, ReqReady=1 after release.
